// File: rtl/phase_stats.sv
// rtl/phase_stats.sv - windowed sum/avg/min/max of phase detector measurements
// Captures each completed detector measurement, discards timed-out ones, publishes per-window stats.
module phase_stats #(
  parameter int LOG2N   = 4,
  parameter int TIMEOUT = 127
) (
  input  logic                 clk_fast,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [6:0]           phase_diff,
  input  logic                 clear,
  input  logic                 stats_ready,
  output logic                 stats_valid,
  output logic [7+LOG2N-1:0]   stats_sum,
  output logic [6:0]           stats_avg,
  output logic [6:0]           stats_min,
  output logic [6:0]           stats_max,
  output logic                 stats_overrun,
  output logic [7:0]           miss_count
);

  localparam int SW = 7 + LOG2N;
  localparam logic [6:0] TMO_LAST = 7'(TIMEOUT - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} state_t;

  state_t            r_state, w_state_next;
  logic [6:0]        r_tcnt, w_tcnt_next;
  logic              r_start_d1, r_start_d2, r_stop_d1, r_stop_d2;
  logic [LOG2N-1:0]  r_count;
  logic [SW-1:0]     r_acc;
  logic [6:0]        r_run_min, r_run_max;
  logic              r_valid, r_overrun;
  logic [SW-1:0]     r_sum;
  logic [6:0]        r_avg, r_min, r_max;
  logic [7:0]        r_miss;

  logic              w_start_edge, w_stop_edge;
  logic              w_accept, w_miss, w_load;
  logic [SW-1:0]     w_sum;
  logic [6:0]        w_min, w_max;

  // A start seen while stop is still high is the tail of the previous echo, not a new measurement.
  assign w_start_edge = r_start_d1 & ~r_start_d2 & ~r_stop_d1;
  assign w_stop_edge  = r_stop_d1 & ~r_stop_d2;

  assign w_sum  = r_acc + SW'(phase_diff);
  assign w_min  = (phase_diff < r_run_min) ? phase_diff : r_run_min;
  assign w_max  = (phase_diff > r_run_max) ? phase_diff : r_run_max;
  assign w_load = w_accept & (&r_count) & ~clear;

  always_comb begin
    w_state_next = r_state;
    w_tcnt_next  = r_tcnt;
    w_accept     = 1'b0;
    w_miss       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_next = S_ARMED;
          w_tcnt_next  = '0;
        end
      end
      S_ARMED: begin
        w_tcnt_next = r_tcnt + 7'd1;
        if (w_stop_edge) begin
          w_accept     = 1'b1;
          w_state_next = S_IDLE;
          w_tcnt_next  = '0;
        end else if (w_start_edge) begin
          w_tcnt_next = '0;
        end else if (r_tcnt == TMO_LAST) begin
          w_miss       = 1'b1;
          w_state_next = S_IDLE;
          w_tcnt_next  = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_tcnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_fast) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tcnt     <= '0;
      r_start_d1 <= 1'b0;
      r_start_d2 <= 1'b0;
      r_stop_d1  <= 1'b0;
      r_stop_d2  <= 1'b0;
      r_count    <= '0;
      r_acc      <= '0;
      r_run_min  <= 7'h7F;
      r_run_max  <= '0;
      r_miss     <= '0;
      r_overrun  <= 1'b0;
      r_valid    <= 1'b0;
      r_sum      <= '0;
      r_avg      <= '0;
      r_min      <= '0;
      r_max      <= '0;
    end else begin
      r_start_d1 <= start;
      r_start_d2 <= r_start_d1;
      r_stop_d1  <= stop;
      r_stop_d2  <= r_stop_d1;

      if (clear) begin
        r_state   <= S_IDLE;
        r_tcnt    <= '0;
        r_count   <= '0;
        r_acc     <= '0;
        r_run_min <= 7'h7F;
        r_run_max <= '0;
        r_miss    <= '0;
        r_overrun <= 1'b0;
      end else begin
        r_state <= w_state_next;
        r_tcnt  <= w_tcnt_next;
        if (w_miss && (r_miss != 8'hFF))
          r_miss <= r_miss + 8'd1;
        if (w_accept) begin
          if (&r_count) begin
            r_count   <= '0;
            r_acc     <= '0;
            r_run_min <= 7'h7F;
            r_run_max <= '0;
          end else begin
            r_count   <= r_count + LOG2N'(1);
            r_acc     <= w_sum;
            r_run_min <= w_min;
            r_run_max <= w_max;
          end
        end
      end

      // A fresh window beats a same-cycle handshake so no result is lost.
      if (w_load) begin
        r_valid <= 1'b1;
        r_sum   <= w_sum;
        r_avg   <= w_sum[SW-1:LOG2N];
        r_min   <= w_min;
        r_max   <= w_max;
        if (r_valid && !stats_ready)
          r_overrun <= 1'b1;
      end else if (r_valid && stats_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign stats_valid   = r_valid;
  assign stats_sum     = r_sum;
  assign stats_avg     = r_avg;
  assign stats_min     = r_min;
  assign stats_max     = r_max;
  assign stats_overrun = r_overrun;
  assign miss_count    = r_miss;

endmodule

// File: tb/tb_phase_stats.sv
// tb/tb_phase_stats.sv - self-checking bench for phase_stats
// Drives start/stop/phase_diff pin timing and compares against an event-level window model.
module tb_phase_stats;

  localparam int LOG2N   = 2;
  localparam int TIMEOUT = 127;
  localparam int SW      = 7 + LOG2N;
  localparam int NS      = 1 << LOG2N;

  logic              clk_fast = 1'b0;
  logic              reset, start, stop, clear, stats_ready;
  logic [6:0]        phase_diff;
  logic              stats_valid, stats_overrun;
  logic [SW-1:0]     stats_sum;
  logic [6:0]        stats_avg, stats_min, stats_max;
  logic [7:0]        miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW+20:0] got_q[$];
  logic [SW+20:0] exp_q[$];
  int             smp_q[$];
  int             model_miss;

  phase_stats #(.LOG2N(LOG2N), .TIMEOUT(TIMEOUT)) dut (
    .clk_fast(clk_fast), .reset(reset), .start(start), .stop(stop),
    .phase_diff(phase_diff), .clear(clear), .stats_ready(stats_ready),
    .stats_valid(stats_valid), .stats_sum(stats_sum), .stats_avg(stats_avg),
    .stats_min(stats_min), .stats_max(stats_max), .stats_overrun(stats_overrun),
    .miss_count(miss_count)
  );

  always #5 clk_fast = ~clk_fast;

  always @(negedge clk_fast)
    if (stats_valid && stats_ready)
      got_q.push_back({stats_sum, stats_avg, stats_min, stats_max});

  initial begin
    #1500000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_fast);
    #1;
  endtask

  // Start pin high for one cycle, stop pin high d cycles later; the detector's final value
  // appears after the edge that samples stop=1 and is garbage on every other cycle.
  task automatic do_meas(input int v, input int d);
    phase_diff = 7'($urandom);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(d - 1);
    stop = 1'b1;
    tick(1);
    phase_diff = 7'(v);
    stop = 1'b0;
    tick(1);
    phase_diff = 7'($urandom);
    tick(2);
  endtask

  function automatic logic [SW+20:0] win(input int s, input int mn, input int mx);
    return {SW'(s), 7'(s / NS), 7'(mn), 7'(mx)};
  endfunction

  task automatic model_push(input int v);
    int s, mn, mx;
    smp_q.push_back(v);
    if (smp_q.size() == NS) begin
      s = 0; mn = 127; mx = 0;
      foreach (smp_q[k]) begin
        s += smp_q[k];
        if (smp_q[k] < mn) mn = smp_q[k];
        if (smp_q[k] > mx) mx = smp_q[k];
      end
      exp_q.push_back(win(s, mn, mx));
      smp_q.delete();
    end
  endtask

  task automatic model_meas(input int v, input int d);
    do_meas(v, d);
    if (d <= TIMEOUT) model_push(v);
    else if (model_miss < 255) model_miss++;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; stats_ready = 1'b1;
    phase_diff = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    n_checks++;
    if (stats_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", stats_valid); end
    n_checks++;
    if ({stats_sum, stats_avg, stats_min, stats_max} !== '0) begin
      n_fail++; $display("FAIL reset_data got %0d/%0d/%0d/%0d exp 0", stats_sum, stats_avg, stats_min, stats_max);
    end
    n_checks++;
    if (stats_overrun !== 1'b0 || miss_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_flags got ovr=%0b miss=%0d exp 0/0", stats_overrun, miss_count);
    end
  endtask

  task automatic test_basic;
    stats_ready = 1'b1;
    got_q.delete();
    do_meas(10, $urandom_range(1, 20));
    do_meas(20, $urandom_range(1, 20));
    do_meas(30, $urandom_range(1, 20));
    do_meas(41, $urandom_range(1, 20));
    n_checks++;
    if (got_q.size() != 1) begin n_fail++; $display("FAIL basic_handshakes got %0d exp 1", got_q.size()); end
    else if (got_q[0] !== win(101, 10, 41)) begin
      n_fail++; $display("FAIL basic_window got %h exp %h", got_q[0], win(101, 10, 41));
    end
    n_checks++;
    if (stats_valid !== 1'b0 || stats_overrun !== 1'b0) begin
      n_fail++; $display("FAIL basic_after got valid=%0b ovr=%0b exp 0/0", stats_valid, stats_overrun);
    end
  endtask

  task automatic test_overrun;
    stats_ready = 1'b0;
    do_meas(10, 3); do_meas(20, 4); do_meas(30, 5); do_meas(41, 6);
    n_checks++;
    if (stats_valid !== 1'b1 || stats_sum !== SW'(101) || stats_overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_first got valid=%0b sum=%0d ovr=%0b exp 1/101/0", stats_valid, stats_sum, stats_overrun);
    end
    for (int i = 0; i < 4; i++) do_meas(5, 2 + i);
    n_checks++;
    if ({stats_sum, stats_avg, stats_min, stats_max} !== win(20, 5, 5)) begin
      n_fail++; $display("FAIL ovr_data got %0d/%0d/%0d/%0d exp 20/5/5/5", stats_sum, stats_avg, stats_min, stats_max);
    end
    n_checks++;
    if (stats_valid !== 1'b1 || stats_overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_flags got valid=%0b ovr=%0b exp 1/1", stats_valid, stats_overrun);
    end
    stats_ready = 1'b1;
    tick(1);
    n_checks++;
    if (stats_valid !== 1'b0 || stats_overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_drain got valid=%0b ovr=%0b exp 0/1", stats_valid, stats_overrun);
    end
  endtask

  task automatic test_timeout;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(TIMEOUT);
    n_checks++;
    if (miss_count !== 8'd0) begin n_fail++; $display("FAIL tmo_early got %0d exp 0", miss_count); end
    tick(1);
    n_checks++;
    if (miss_count !== 8'd1) begin n_fail++; $display("FAIL tmo_count got %0d exp 1", miss_count); end
    stop = 1'b1;
    tick(1);
    phase_diff = 7'd100;
    stop = 1'b0;
    tick(3);
    got_q.delete();
    do_meas(1, 7); do_meas(2, 1); do_meas(3, 9); do_meas(4, 2);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== win(10, 1, 4)) begin
      n_fail++; $display("FAIL tmo_late_stop got n=%0d w=%h exp 1 %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : '0, win(10, 1, 4));
    end
  endtask

  task automatic test_spurious;
    stop = 1'b1;
    tick(1);
    phase_diff = 7'd99;
    stop = 1'b0;
    tick(3);
    stop = 1'b1;
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
    stop = 1'b0;
    tick(TIMEOUT + 10);
    n_checks++;
    if (miss_count !== 8'd1) begin n_fail++; $display("FAIL spur_miss got %0d exp 1", miss_count); end
    stop = 1'b1;
    tick(1);
    phase_diff = 7'd99;
    stop = 1'b0;
    tick(3);
    got_q.delete();
    do_meas(60, 3); do_meas(61, 3); do_meas(62, 3); do_meas(63, 3);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== win(246, 60, 63)) begin
      n_fail++; $display("FAIL spur_window got n=%0d w=%h exp 1 %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : '0, win(246, 60, 63));
    end
  endtask

  task automatic test_clear;
    stats_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_meas(3, 2);
    do_meas(50, 4);
    do_meas(60, 4);
    n_checks++;
    if (stats_overrun !== 1'b1 || miss_count !== 8'd1) begin
      n_fail++; $display("FAIL clr_before got ovr=%0b miss=%0d exp 1/1", stats_overrun, miss_count);
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    n_checks++;
    if (miss_count !== 8'd0 || stats_overrun !== 1'b0) begin
      n_fail++; $display("FAIL clr_flags got miss=%0d ovr=%0b exp 0/0", miss_count, stats_overrun);
    end
    n_checks++;
    if (stats_valid !== 1'b1 || stats_sum !== SW'(12)) begin
      n_fail++; $display("FAIL clr_pending got valid=%0b sum=%0d exp 1/12", stats_valid, stats_sum);
    end
    stats_ready = 1'b1;
    tick(1);
    got_q.delete();
    for (int i = 0; i < 4; i++) do_meas(7, 5);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== win(28, 7, 7)) begin
      n_fail++; $display("FAIL clr_window got n=%0d w=%h exp 1 %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : '0, win(28, 7, 7));
    end
  endtask

  task automatic test_random;
    int v, d;
    stats_ready = 1'b1;
    got_q.delete(); exp_q.delete(); smp_q.delete();
    model_miss = 0;
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(0, 127);
      if ($urandom_range(0, 3) == 0) d = $urandom_range(TIMEOUT - 2, TIMEOUT + 3);
      else d = $urandom_range(1, 12);
      model_meas(v, d);
    end
    n_checks++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        n_checks++;
        if (got_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_window%0d got %h exp %h", k, got_q[k], exp_q[k]); end
      end
    end
    n_checks++;
    if (miss_count !== 8'(model_miss)) begin n_fail++; $display("FAIL rand_miss got %0d exp %0d", miss_count, model_miss); end
  endtask

  task automatic test_saturate_reset;
    for (int i = 0; i < 300; i++) begin
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(TIMEOUT + 3);
    end
    n_checks++;
    if (miss_count !== 8'd255) begin n_fail++; $display("FAIL sat_miss got %0d exp 255", miss_count); end
    do_meas(90, 3);
    do_meas(91, 3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_checks++;
    if ({stats_valid, stats_sum, stats_avg, stats_min, stats_max, stats_overrun, miss_count} !== '0) begin
      n_fail++; $display("FAIL rst_mid got v=%0b %0d/%0d/%0d/%0d ovr=%0b miss=%0d exp all 0", stats_valid,
                         stats_sum, stats_avg, stats_min, stats_max, stats_overrun, miss_count);
    end
    got_q.delete();
    do_meas(100, 2); do_meas(101, 2); do_meas(102, 2); do_meas(103, 2);
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== win(406, 100, 103)) begin
      n_fail++; $display("FAIL rst_fresh got n=%0d w=%h exp 1 %h", got_q.size(),
                         (got_q.size() > 0) ? got_q[0] : '0, win(406, 100, 103));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_timeout();
    test_spurious();
    test_clear();
    test_random();
    test_saturate_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/phase_stats.md
Name: phase_stats

Overview:
- Sits directly downstream of the phase detector, in the same `clk_fast` domain.
- Watches the detector's start/stop strobes to know when each 7-bit `phase_diff` measurement has completed, then captures the value.
- Accumulates 2^LOG2N accepted measurements per window and publishes sum, average, min and max through a valid/ready handshake.
- Discards measurements that time out, and counts them.

Parameters:
- LOG2N, 4: log2 of samples per window (1..8).
- TIMEOUT, 127: max `clk_fast` cycles from an accepted start edge to a stop edge before the measurement is discarded (1..127).

Ports:
- clk_fast  in  1  measurement clock, shared with the detector.
- reset  in  1  synchronous, active-high.
- start  in  1  same start signal the detector receives.
- stop  in  1  same stop/echo signal the detector receives.
- phase_diff  in  7  detector output.
- clear  in  1  synchronous; abandons the current window and zeroes `miss_count`.
- stats_ready  in  1  consumer accepts results.
- stats_valid  out  1  result set held and valid.
- stats_sum  out  7+LOG2N  sum of window samples.
- stats_avg  out  7  `stats_sum >> LOG2N` (truncating).
- stats_min  out  7  minimum sample in the window.
- stats_max  out  7  maximum sample in the window.
- stats_overrun  out  1  sticky; a window completed while `stats_valid` was still high.
- miss_count  out  8  saturating count of timed-out measurements.

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal `armed`=0, timeout counter=0, window sample count=0, accumulator=0, running min=127, running max=0.
  - `start`/`stop` delay registers cleared to 0.
- Edge detection:
  - `start` and `stop` each pass through two registers (d1, d2).
  - Start edge = `start_d1 & ~start_d2 & ~stop_d1`.
  - Stop edge = `stop_d1 & ~stop_d2`.
- Capture timing:
  - The detector freezes `phase_diff` on the edge where it samples `stop`=1.
  - On the following edge this block sees the stop edge and samples `phase_diff`; that value is final.
  - No other cycle samples `phase_diff`.
- States (2):
  - IDLE (`armed`=0): a start edge sets `armed`=1 and timeout counter=0. Stop edges are ignored.
  - ARMED: timeout counter increments every cycle.
    - Stop edge → accept sample, go to IDLE.
    - Counter reaches TIMEOUT with no stop edge → discard, `miss_count`++ (saturate at 255), go to IDLE.
    - Start edge → restart the timeout counter and stay ARMED (matches the detector restarting).
    - Stop edge and timeout on the same cycle → the stop edge wins (sample accepted).
- Accepting a sample:
  - accumulator += `phase_diff`; min/max updated; sample count++.
  - When the sample count reaches 2^LOG2N (on the same cycle the last sample is added), the output registers load:
    - `stats_sum` = final sum; `stats_avg` = final sum >> LOG2N.
    - `stats_min` / `stats_max` include the last sample.
  - The accumulator, count, min (127) and max (0) then reinitialise so the next window starts on the next cycle with no lost sample.
  - `stats_valid` goes to 1.
- Handshake:
  - Outputs are stable while `stats_valid`=1.
  - `stats_valid` clears on the cycle after sampling `stats_valid & stats_ready`.
  - A window completing while `stats_valid`=1 and `stats_ready`=0 overwrites the outputs, keeps `stats_valid`=1 and sets `stats_overrun`.
  - A window completing on the same cycle as the handshake loads new data and leaves `stats_valid`=1, with no overrun.
  - `stats_overrun` clears only on `reset` or `clear`.
- Width rules:
  - The accumulator is 7+LOG2N bits and cannot overflow.
  - `miss_count` saturates at 255 and never wraps.
- `clear`:
  - Same cycle effect as reset for: window state, `armed`, `miss_count`, `stats_overrun`.
  - Does not drop a pending `stats_valid` or its data.
  - Has priority over a simultaneous sample accept.
- `reset` mid-window:
  - All partial accumulation is lost.
  - The first window after reset needs a full 2^LOG2N fresh samples.

Test Plan (LOG2N=2, TIMEOUT=127 unless noted):
1. Four start/stop pairs yielding `phase_diff` 10, 20, 30, 41; `stats_ready`=1 → one-cycle `stats_valid` with sum=101, avg=25, min=10, max=41; `stats_overrun`=0.
2. Same four samples with `stats_ready`=0, then four more (5, 5, 5, 5) → outputs sum=20, avg=5, min=5, max=5; `stats_valid`=1 held; `stats_overrun`=1. Raising `stats_ready` drops `stats_valid` on the next cycle.
3. Start edge, then no stop for 127 cycles → `miss_count`=1, no sample accepted. A subsequent stop edge is ignored (`phase_diff` not captured).
4. Stop pulse with no prior start, plus stop held high while start pulses → no sample accepted, no start edge, counters unchanged.
5. Two samples accepted, then `clear`, then four samples of 7 → sum=28, min=max=avg=7. `miss_count` is 0 after `clear`.
6. 300 consecutive timeouts → `miss_count` saturates at 255. Then `reset` mid-window → all outputs 0 on the next cycle.
